// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: default widths, WB control
// bit positions and the data-memory power-up image.
package mem_stage_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 8;

   localparam int unsigned REGWRITE = 1;
   localparam int unsigned MEMTOREG = 0;

   localparam int unsigned INIT_WORDS = 9;
   localparam logic [31:0] INIT_IMAGE [INIT_WORDS] = '{
      32'h002300AA, 32'h10654321, 32'h00100022,
      32'h8C123456, 32'h8F123456, 32'hAD654321,
      32'h13012345, 32'hAC654321, 32'h12012345
   };

endpackage

// File: rtl/mem_stage_data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read,
// preloaded with the package image (all remaining words zero).
module data_memory
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef logic [DATA_W-1:0] mem_t [DEPTH];

   function automatic mem_t build_image();
      mem_t img;
      img = '{default: '0};
      for (int unsigned i = 0; i < INIT_WORDS; i++) begin
         if (i < DEPTH) img[i] = DATA_W'(INIT_IMAGE[i]);
      end
      return img;
   endfunction

   // Power-up contents only; reset deliberately leaves the memory untouched.
   mem_t mem = build_image();

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data memory access, branch
// resolution and the MEM/WB pipeline register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        wb_ctlout,
   input  logic              branch,
   input  logic              memread,
   input  logic              memwrite,
   input  logic              zero,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] rdata2out,
   input  logic [4:0]        five_bit_muxout,
   output logic              MEM_PCSrc,
   output logic              MEM_WB_regwrite,
   output logic              MEM_WB_memtoreg,
   output logic [DATA_W-1:0] read_data,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [4:0]        mem_write_reg
);

   logic [DATA_W-1:0] mem_word;
   logic [DATA_W-1:0] gated_read;
   logic              mem_we;

   assign MEM_PCSrc = branch & zero;

   // A store on the reset edge is dropped along with the pipeline contents.
   assign mem_we = memwrite & ~rst;

   data_memory #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_data_memory (
      .clk   (clk),
      .we    (mem_we),
      .idx   (alu_result[ADDR_W-1:0]),
      .wdata (rdata2out),
      .rdata (mem_word)
   );

   // Combinational read of the pre-edge word gives read-before-write.
   assign gated_read = memread ? mem_word : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         MEM_WB_regwrite <= 1'b0;
         MEM_WB_memtoreg <= 1'b0;
         read_data       <= '0;
         mem_alu_result  <= '0;
         mem_write_reg   <= '0;
      end else begin
         MEM_WB_regwrite <= wb_ctlout[REGWRITE];
         MEM_WB_memtoreg <= wb_ctlout[MEMTOREG];
         read_data       <= gated_read;
         mem_alu_result  <= alu_result;
         mem_write_reg   <= five_bit_muxout;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// traffic compared against an array-based memory model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  wb_ctlout;
   logic        branch;
   logic        memread;
   logic        memwrite;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] rdata2out;
   logic [4:0]  five_bit_muxout;
   logic        MEM_PCSrc;
   logic        MEM_WB_regwrite;
   logic        MEM_WB_memtoreg;
   logic [31:0] read_data;
   logic [31:0] mem_alu_result;
   logic [4:0]  mem_write_reg;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] model [256];

   logic        exp_rw, exp_mtr;
   logic [31:0] exp_rd, exp_alu;
   logic [4:0]  exp_wr;

   mem_stage #(.DATA_W(32), .ADDR_W(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .wb_ctlout       (wb_ctlout),
      .branch          (branch),
      .memread         (memread),
      .memwrite        (memwrite),
      .zero            (zero),
      .alu_result      (alu_result),
      .rdata2out       (rdata2out),
      .five_bit_muxout (five_bit_muxout),
      .MEM_PCSrc       (MEM_PCSrc),
      .MEM_WB_regwrite (MEM_WB_regwrite),
      .MEM_WB_memtoreg (MEM_WB_memtoreg),
      .read_data       (read_data),
      .mem_alu_result  (mem_alu_result),
      .mem_write_reg   (mem_write_reg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_pcsrc();
      #1;
      check("pcsrc", {31'd0, MEM_PCSrc}, {31'd0, branch && zero});
   endtask

   // Predict the MEM/WB contents from the current inputs, clock once,
   // compare, then apply any store to the model.
   task automatic step();
      int unsigned word;
      word = alu_result % 256;
      if (rst) begin
         exp_rw = 0; exp_mtr = 0; exp_rd = 0; exp_alu = 0; exp_wr = 0;
      end else begin
         exp_rw  = wb_ctlout[1];
         exp_mtr = wb_ctlout[0];
         exp_rd  = memread ? model[word] : 32'd0;
         exp_alu = alu_result;
         exp_wr  = five_bit_muxout;
      end
      @(posedge clk);
      #1;
      if (memwrite && !rst) model[word] = rdata2out;
      check("regwrite",  {31'd0, MEM_WB_regwrite}, {31'd0, exp_rw});
      check("memtoreg",  {31'd0, MEM_WB_memtoreg}, {31'd0, exp_mtr});
      check("read_data", read_data, exp_rd);
      check("alu_result", mem_alu_result, exp_alu);
      check("write_reg", {27'd0, mem_write_reg}, {27'd0, exp_wr});
   endtask

   task automatic idle();
      rst = 0; wb_ctlout = 2'b00; branch = 0; memread = 0; memwrite = 0;
      zero = 0; alu_result = 0; rdata2out = 0; five_bit_muxout = 0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) model[i] = 32'd0;
      model[0] = 32'h002300AA; model[1] = 32'h10654321; model[2] = 32'h00100022;
      model[3] = 32'h8C123456; model[4] = 32'h8F123456; model[5] = 32'hAD654321;
      model[6] = 32'h13012345; model[7] = 32'hAC654321; model[8] = 32'h12012345;

      // Reset for two cycles with busy inputs; PCSrc still follows branch & zero.
      idle();
      rst = 1; wb_ctlout = 2'b11; memread = 1; alu_result = 32'd3;
      five_bit_muxout = 5'd7; branch = 1; zero = 1;
      check_pcsrc();
      step();
      check("rst_read_data", read_data, 32'd0);
      zero = 0;
      check_pcsrc();
      step();

      // Load from word 3.
      idle();
      memread = 1; alu_result = 32'd3; wb_ctlout = 2'b11; five_bit_muxout = 5'd9;
      step();
      check("ld3_data", read_data, 32'h8C123456);
      check("ld3_reg", {27'd0, mem_write_reg}, 32'd9);

      // Store then load at word 20.
      idle();
      memwrite = 1; alu_result = 32'd20; rdata2out = 32'hDEADBEEF;
      step();
      idle();
      memread = 1; alu_result = 32'd20;
      step();
      check("st_ld20", read_data, 32'hDEADBEEF);

      // Simultaneous read and write returns the old word.
      idle();
      memread = 1; memwrite = 1; alu_result = 32'd21; rdata2out = 32'hDEADBEEF;
      step();
      check("rbw_old", read_data, 32'd0);
      idle();
      memread = 1; alu_result = 32'd21;
      step();
      check("rbw_new", read_data, 32'hDEADBEEF);

      // Branch decision truth table.
      idle();
      branch = 1; zero = 1; check_pcsrc();
      check("pcsrc_taken", {31'd0, MEM_PCSrc}, 32'd1);
      branch = 1; zero = 0; check_pcsrc();
      branch = 0; zero = 1; check_pcsrc();
      branch = 0; zero = 0; check_pcsrc();

      // Gated read and address wrap.
      idle();
      alu_result = 32'd1;
      step();
      check("gated", read_data, 32'd0);
      memread = 1; alu_result = 32'd257;
      step();
      check("wrap", read_data, 32'h10654321);

      // Store during reset is suppressed.
      idle();
      rst = 1; memwrite = 1; alu_result = 32'd0; rdata2out = 32'h12345678;
      wb_ctlout = 2'b11;
      step();
      idle();
      memread = 1; alu_result = 32'd0;
      step();
      check("rst_nowrite", read_data, 32'h002300AA);

      // Randomized traffic concentrated on a few words to force reuse.
      for (int n = 0; n < 300; n++) begin
         rst             = ($urandom_range(0, 19) == 0);
         wb_ctlout       = 2'($urandom_range(0, 3));
         branch          = 1'($urandom_range(0, 1));
         zero            = 1'($urandom_range(0, 1));
         memread         = 1'($urandom_range(0, 1));
         memwrite        = ($urandom_range(0, 2) == 0);
         alu_result      = ($urandom() & 32'hFFFF_FF00) | 32'($urandom_range(0, 15));
         rdata2out       = $urandom();
         five_bit_muxout = 5'($urandom_range(0, 31));
         check_pcsrc();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
